mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) round-robin arbiter in front of a single-port
// memory with fixed read latency. One access outstanding at a time.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            f_req,
    input  logic [XLEN-1:0] f_addr,
    output logic            f_done,
    output logic [XLEN-1:0] f_rdata,
    input  logic            d_req,
    input  logic            d_wenable,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_done,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_wenable,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic            we_r;
    logic            owner_r;   // 1 = data requester owns the access
    logic            last_r;    // 1 = data requester was granted most recently
    logic [XLEN-1:0] f_rdata_r;
    logic [XLEN-1:0] d_rdata_r;
    logic            f_done_r;
    logic            d_done_r;
    logic            mem_we_r;
    logic            busy_r;

    logic            any_req_s;
    logic            pick_d_s;

    // Round-robin choice: data wins only if fetch is idle or fetch won last time.
    assign any_req_s = f_req | d_req;
    assign pick_d_s  = d_req & (~f_req | ~last_r);

    // Arbitration FSM with latched access and registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            addr_r    <= {XLEN{1'b0}};
            wdata_r   <= {XLEN{1'b0}};
            we_r      <= 1'b0;
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
            f_rdata_r <= {XLEN{1'b0}};
            d_rdata_r <= {XLEN{1'b0}};
            f_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            f_done_r <= 1'b0;
            d_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_r  <= ST_ACCESS;
                        owner_r  <= pick_d_s;
                        last_r   <= pick_d_s;
                        addr_r   <= pick_d_s ? d_addr : f_addr;
                        wdata_r  <= pick_d_s ? d_wdata : {XLEN{1'b0}};
                        we_r     <= pick_d_s & d_wenable;
                        mem_we_r <= pick_d_s & d_wenable;
                        cnt_r    <= CNT_LOAD;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Writes finish in one cycle; reads wait out the counter.
                    if (we_r || (cnt_r == 4'd0)) begin
                        state_r  <= ST_RESP;
                        mem_we_r <= 1'b0;
                        if (owner_r) begin
                            d_done_r <= 1'b1;
                            if (!we_r) begin
                                d_rdata_r <= mem_rdata;
                            end else begin
                                d_rdata_r <= d_rdata_r;
                            end
                        end else begin
                            f_done_r  <= 1'b1;
                            f_rdata_r <= mem_rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_we_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign f_done      = f_done_r;
    assign d_done      = d_done_r;
    assign f_rdata     = f_rdata_r;
    assign d_rdata     = d_rdata_r;
    assign mem_wenable = mem_we_r;
    assign mem_addr    = addr_r;
    assign mem_wdata   = wdata_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (READ_LATENCY 2, plus 1 and 4 sweep).
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        f_req, d_req, d_wenable;
    logic [31:0] f_addr, d_addr, d_wdata, rd_val;
    logic        f_done, d_done, mem_wenable, busy;
    logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;

    logic        s_f_req, s_zero;
    logic [31:0] s_f_addr, s_zero_w, s_rdata;
    logic        f_done1, d_done1, mem_we1, busy1;
    logic [31:0] f_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic        f_done4, d_done4, mem_we4, busy4;
    logic [31:0] f_rdata4, d_rdata4, mem_addr4, mem_wdata4;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.XLEN(32), .READ_LATENCY(2)) u_dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_wenable(d_wenable), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_wenable(mem_wenable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(rd_val), .busy(busy)
    );

    mem_port_arbiter #(.XLEN(32), .READ_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .f_req(s_f_req), .f_addr(s_f_addr), .f_done(f_done1), .f_rdata(f_rdata1),
        .d_req(s_zero), .d_wenable(s_zero), .d_addr(s_zero_w), .d_wdata(s_zero_w),
        .d_done(d_done1), .d_rdata(d_rdata1),
        .mem_wenable(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(s_rdata), .busy(busy1)
    );

    mem_port_arbiter #(.XLEN(32), .READ_LATENCY(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .f_req(s_f_req), .f_addr(s_f_addr), .f_done(f_done4), .f_rdata(f_rdata4),
        .d_req(s_zero), .d_wenable(s_zero), .d_addr(s_zero_w), .d_wdata(s_zero_w),
        .d_done(d_done4), .d_rdata(d_rdata4),
        .mem_wenable(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(s_rdata), .busy(busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    int done1_cyc, done4_cyc, done1_cnt, done4_cnt;

    initial begin
        reset = 1'b0;
        f_req = 1'b0; d_req = 1'b0; d_wenable = 1'b0;
        f_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; rd_val = 32'd0;
        s_f_req = 1'b0; s_zero = 1'b0; s_f_addr = 32'd0; s_zero_w = 32'd0; s_rdata = 32'd0;

        // Reset state
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fdone", 32'(f_done), 32'd0);
        check("rst_ddone", 32'(d_done), 32'd0);
        check("rst_mwe", 32'(mem_wenable), 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        check("rst_frdata", f_rdata, 32'd0);
        check("rst_drdata", d_rdata, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Fetch read, latency 2
        f_req = 1'b1; f_addr = 32'h0000_0100; rd_val = 32'hAB12_CD34;
        step();
        check("fr_c1_addr", mem_addr, 32'h0000_0100);
        check("fr_c1_busy", 32'(busy), 32'd1);
        check("fr_c1_done", 32'(f_done), 32'd0);
        check("fr_c1_we", 32'(mem_wenable), 32'd0);
        step();
        check("fr_c2_addr", mem_addr, 32'h0000_0100);
        check("fr_c2_done", 32'(f_done), 32'd0);
        step();
        check("fr_c3_fdone", 32'(f_done), 32'd1);
        check("fr_c3_ddone", 32'(d_done), 32'd0);
        check("fr_c3_rdata", f_rdata, 32'hAB12_CD34);
        f_req = 1'b0;
        step();
        check("fr_c4_fdone", 32'(f_done), 32'd0);
        check("fr_c4_busy", 32'(busy), 32'd0);

        // Data write
        d_req = 1'b1; d_wenable = 1'b1; d_addr = 32'hDEAD_BEEC; d_wdata = 32'hCAFE_D00D;
        step();
        check("wr_c1_we", 32'(mem_wenable), 32'd1);
        check("wr_c1_addr", mem_addr, 32'hDEAD_BEEC);
        check("wr_c1_wdata", mem_wdata, 32'hCAFE_D00D);
        check("wr_c1_done", 32'(d_done), 32'd0);
        step();
        check("wr_c2_we", 32'(mem_wenable), 32'd0);
        check("wr_c2_ddone", 32'(d_done), 32'd1);
        check("wr_c2_drdata", d_rdata, 32'd0);
        d_req = 1'b0; d_wenable = 1'b0;
        step();
        check("wr_c3_ddone", 32'(d_done), 32'd0);

        // Simultaneous requests after reset, both held
        do_reset();
        f_req = 1'b1; d_req = 1'b1; d_wenable = 1'b0;
        f_addr = 32'h0000_0200; d_addr = 32'h0000_0300; rd_val = 32'h1111_1111;
        step();
        check("rr_c1_addr", mem_addr, 32'h0000_0200);
        step();
        step();
        check("rr_c3_fdone", 32'(f_done), 32'd1);
        check("rr_c3_ddone", 32'(d_done), 32'd0);
        check("rr_c3_frdata", f_rdata, 32'h1111_1111);
        rd_val = 32'h2222_2222;
        step();
        check("rr_c4_busy", 32'(busy), 32'd0);
        step();
        check("rr_c5_addr", mem_addr, 32'h0000_0300);
        check("rr_c5_fdone", 32'(f_done), 32'd0);
        step();
        step();
        check("rr_c7_ddone", 32'(d_done), 32'd1);
        check("rr_c7_fdone", 32'(f_done), 32'd0);
        check("rr_c7_drdata", d_rdata, 32'h2222_2222);
        check("rr_c7_frdata", f_rdata, 32'h1111_1111);
        step();
        step();
        check("rr_c9_addr", mem_addr, 32'h0000_0200);
        f_req = 1'b0; d_req = 1'b0;
        step();
        step();
        check("rr_c11_fdone", 32'(f_done), 32'd1);
        check("rr_c11_ddone", 32'(d_done), 32'd0);
        check("rr_c11_frdata", f_rdata, 32'h2222_2222);
        step();

        // Requester input change after grant
        d_req = 1'b1; d_wenable = 1'b0; d_addr = 32'h0000_0010;
        step();
        d_addr = 32'h0000_0020;
        check("chg_c1_addr", mem_addr, 32'h0000_0010);
        step();
        check("chg_c2_addr", mem_addr, 32'h0000_0010);
        step();
        check("chg_c3_ddone", 32'(d_done), 32'd1);
        d_req = 1'b0;
        step();

        // Reset in the middle of a read
        f_req = 1'b1; f_addr = 32'h0000_0400; rd_val = 32'h3333_3333;
        step();
        check("mr_c1_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_maddr", mem_addr, 32'd0);
        check("mr_frdata", f_rdata, 32'd0);
        check("mr_fdone", 32'(f_done), 32'd0);
        f_req = 1'b0;
        step();
        check("mr_fdone2", 32'(f_done), 32'd0);
        check("mr_mwe", 32'(mem_wenable), 32'd0);
        reset = 1'b1;
        step();

        // Latency sweep on READ_LATENCY 1 and 4 (request dropped mid-access)
        done1_cyc = -1; done4_cyc = -1; done1_cnt = 0; done4_cnt = 0;
        s_f_req = 1'b1; s_f_addr = 32'h0000_0500; s_rdata = 32'h4444_4444;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 1) s_f_req = 1'b0;
            if (f_done1) begin done1_cyc = i; done1_cnt++; end
            if (f_done4) begin done4_cyc = i; done4_cnt++; end
            if (i == 3) check("sw1_c3_busy", 32'(busy1), 32'd0);
        end
        check("sw1_done_cyc", 32'(done1_cyc), 32'd2);
        check("sw4_done_cyc", 32'(done4_cyc), 32'd5);
        check("sw1_done_cnt", 32'(done1_cnt), 32'd1);
        check("sw4_done_cnt", 32'(done4_cnt), 32'd1);
        check("sw1_rdata", f_rdata1, 32'h4444_4444);
        check("sw4_rdata", f_rdata4, 32'h4444_4444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
